sd_spi_master: RTL

- SPI-mode SD card initiator used by the RK8E disk controller. It drives the sdCS, sdSCLK and sdMOSI lines and samples sdMISO.
- Provides two services: a raw single-byte transfer engine, and a command sequencer. The sequencer frames a 6-byte SD command and polls for the R1 response.
- In the PDP8e top level it talks to the card, or to the sdsim responder in simulation. It frees the RK8E state machine from bit-level timing.

---
 rtl/sd_spi_master.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_master.sv
// SPI-mode SD card initiator: a mode-0 byte engine plus a sequencer that frames
// a 6-byte SD command, polls for R1 and clocks out one trailer byte.
module sd_spi_master #(
  parameter int DIV_FAST = 2,
  parameter int DIV_SLOW = 64,
  parameter int R1_TRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow,
  input  logic        cs_en,
  input  logic        xfer_start,
  input  logic [7:0]  tx_byte,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        cs_hold,
  output logic        busy,
  output logic        xfer_done,
  output logic [7:0]  rx_byte,
  output logic        cmd_done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        sdCS,
  output logic        sdSCLK,
  output logic        sdMOSI,
  input  logic        sdMISO
);

  localparam int CW = $clog2(DIV_SLOW + 1);
  localparam int PW = $clog2(R1_TRIES + 1);

  localparam logic [1:0] BE_IDLE = 2'd0;
  localparam logic [1:0] BE_LOAD = 2'd1;
  localparam logic [1:0] BE_LOW  = 2'd2;
  localparam logic [1:0] BE_HIGH = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_XFER = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_POLL = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [1:0]    be_state_reg;
  logic [CW-1:0] div_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          sclk_reg;
  logic          mosi_reg;
  logic [7:0]    rx_byte_reg;

  logic [2:0]    seq_state_reg;
  logic [47:0]   frame_reg;
  logic [2:0]    byte_cnt_reg;
  logic [PW-1:0] poll_cnt_reg;
  logic          cs_hold_reg;
  logic          cs_reg;
  logic [7:0]    r1_reg;
  logic          timeout_reg;
  logic          xfer_done_reg;
  logic          cmd_done_reg;

  logic       seq_idle;
  logic       raw_go;
  logic       seq_go;
  logic       be_go;
  logic [7:0] be_tx;
  logic       half_end;
  logic       be_fin;

  // cmd_start has priority over xfer_start in the same idle cycle
  assign seq_idle = (seq_state_reg == S_IDLE);
  assign raw_go   = seq_idle && xfer_start && !cmd_start;
  assign seq_go   = ((seq_state_reg == S_SEND) || (seq_state_reg == S_POLL) ||
                     (seq_state_reg == S_FIN)) && (be_state_reg == BE_IDLE);
  assign be_go    = raw_go || seq_go;
  assign be_tx    = (seq_state_reg == S_SEND) ? frame_reg[47:40] :
                    (seq_idle ? tx_byte : 8'hFF);
  assign half_end = (cnt_reg == div_reg - CW'(1));
  assign be_fin   = (be_state_reg == BE_LOW) && half_end && (bit_cnt_reg == 4'd8);

  // Byte engine: one load cycle, then 8 low/high bit periods and a closing low half
  always_ff @(posedge clk) begin
    if (reset) begin
      be_state_reg <= BE_IDLE;
      div_reg      <= CW'(DIV_FAST);
      cnt_reg      <= '0;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'hFF;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b1;
      rx_byte_reg  <= 8'hFF;
    end else begin
      case (be_state_reg)
        BE_IDLE: begin
          if (be_go) begin
            shift_reg    <= be_tx;
            mosi_reg     <= be_tx[7];
            div_reg      <= slow ? CW'(DIV_SLOW) : CW'(DIV_FAST);
            cnt_reg      <= '0;
            bit_cnt_reg  <= 4'd0;
            be_state_reg <= BE_LOAD;
          end
        end
        BE_LOAD: begin
          cnt_reg      <= '0;
          be_state_reg <= BE_LOW;
        end
        BE_LOW: begin
          if (half_end) begin
            cnt_reg <= '0;
            if (bit_cnt_reg == 4'd8) begin
              rx_byte_reg  <= shift_reg;
              mosi_reg     <= 1'b1;
              be_state_reg <= BE_IDLE;
            end else begin
              sclk_reg     <= 1'b1;
              shift_reg    <= {shift_reg[6:0], sdMISO};
              bit_cnt_reg  <= bit_cnt_reg + 4'd1;
              be_state_reg <= BE_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          if (half_end) begin
            cnt_reg      <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= (bit_cnt_reg == 4'd8) ? 1'b1 : shift_reg[7];
            be_state_reg <= BE_LOW;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_state_reg <= S_IDLE;
      frame_reg     <= '0;
      byte_cnt_reg  <= 3'd0;
      poll_cnt_reg  <= '0;
      cs_hold_reg   <= 1'b0;
      cs_reg        <= 1'b1;
      r1_reg        <= 8'hFF;
      timeout_reg   <= 1'b0;
      xfer_done_reg <= 1'b0;
      cmd_done_reg  <= 1'b0;
    end else begin
      xfer_done_reg <= 1'b0;
      cmd_done_reg  <= 1'b0;
      case (seq_state_reg)
        S_IDLE: begin
          cs_reg <= ~cs_en;
          if (cmd_start) begin
            frame_reg     <= {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1};
            cs_hold_reg   <= cs_hold;
            byte_cnt_reg  <= 3'd0;
            poll_cnt_reg  <= '0;
            cs_reg        <= 1'b0;
            seq_state_reg <= S_SEND;
          end else if (xfer_start) begin
            seq_state_reg <= S_XFER;
          end
        end
        S_XFER: begin
          cs_reg <= ~cs_en;
          if (be_fin) begin
            xfer_done_reg <= 1'b1;
            seq_state_reg <= S_IDLE;
          end
        end
        S_SEND: begin
          cs_reg <= 1'b0;
          if (be_fin) begin
            frame_reg <= {frame_reg[39:0], 8'h00};
            if (byte_cnt_reg == 3'd5) begin
              seq_state_reg <= S_POLL;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
            end
          end
        end
        S_POLL: begin
          cs_reg <= 1'b0;
          if (be_fin) begin
            // A valid R1 always has its MSB clear; 0xFF means the card is still busy
            if (!shift_reg[7]) begin
              r1_reg        <= shift_reg;
              timeout_reg   <= 1'b0;
              seq_state_reg <= S_FIN;
            end else if (poll_cnt_reg == PW'(R1_TRIES - 1)) begin
              r1_reg        <= 8'hFF;
              timeout_reg   <= 1'b1;
              seq_state_reg <= S_FIN;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + PW'(1);
            end
          end
        end
        S_FIN: begin
          cs_reg <= 1'b0;
          if (be_fin) begin
            cmd_done_reg  <= 1'b1;
            cs_reg        <= ~cs_hold_reg;
            seq_state_reg <= S_IDLE;
          end
        end
        default: begin
          seq_state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = !seq_idle;
  assign xfer_done = xfer_done_reg;
  assign rx_byte   = rx_byte_reg;
  assign cmd_done  = cmd_done_reg;
  assign r1        = r1_reg;
  assign timeout   = timeout_reg;
  assign sdCS      = cs_reg;
  assign sdSCLK    = sclk_reg;
  assign sdMOSI    = mosi_reg;

endmodule
